// File: rtl/xalu_ise_mc.sv
// xalu_ise_mc: Ascon sigma_lo/sigma_hi ISE unit with a PIPE-deep (1..3) pipeline and valid/ready handshake.
// Optional macro XALU_ISE_PAIR_CACHE_EN keeps the last legal {x,row} and its 64-bit row result for single-cycle reuse.
module xalu_ise_mc #(
  parameter logic [1:0] ISE_V = 2'b11,
  parameter int         PIPE  = 1
) (
  input  logic        ise_clk,
  input  logic        ise_rst,
  input  logic [5:0]  ise_fn,
  input  logic [6:0]  ise_imm,
  input  logic [31:0] ise_in1,
  input  logic [31:0] ise_in2,
  input  logic        ise_val,
  output logic        ise_rdy,
  output logic        ise_oval,
  output logic        ise_ill,
  output logic [31:0] ise_out
);

  if (PIPE < 1 || PIPE > 3) begin : g_bad_pipe
    $error("xalu_ise_mc: PIPE must be in 1..3");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
    return (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

  function automatic logic [11:0] row_amt(input logic [4:0] row);
    case (row)
      5'd0:    return {6'd19, 6'd28};
      5'd1:    return {6'd61, 6'd39};
      5'd2:    return {6'd1,  6'd6};
      5'd3:    return {6'd10, 6'd17};
      5'd4:    return {6'd7,  6'd41};
      default: return 12'd0;
    endcase
  endfunction

  logic        en, sel, legal, acc, hit;
  logic [5:0]  amt_a, amt_b;
  logic [63:0] x_in, rota_in, rotb_in, r_in, hit_r;
  logic [31:0] res_in, hit_res;
  logic        unused_fn;

  assign en        = ISE_V[1];
  assign unused_fn = ^ise_fn[5:2];
  assign sel       = (ise_fn[1:0] == 2'b01) && !ise_imm[6];
  assign legal     = ise_imm[4:0] <= 5'd4;
  assign x_in      = {ise_in2, ise_in1};
  assign {amt_a, amt_b} = row_amt(ise_imm[4:0]);
  assign rota_in   = ror64(x_in, amt_a);
  assign rotb_in   = ror64(x_in, amt_b);
  assign r_in      = x_in ^ rota_in ^ rotb_in;
  assign res_in    = ise_imm[5] ? r_in[63:32] : r_in[31:0];
  assign hit_res   = ise_imm[5] ? hit_r[63:32] : hit_r[31:0];

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        rdy_q, oval_q, ill_q;
  logic [31:0] out_q;

  assign acc = en && ise_val && rdy_q && sel;

`ifdef XALU_ISE_PAIR_CACHE_EN
  logic        c_vld_q;
  logic [68:0] c_tag_q;
  logic [63:0] c_r_q;

  assign hit   = c_vld_q && (c_tag_q == {x_in, ise_imm[4:0]});
  assign hit_r = c_r_q;

  always_ff @(posedge ise_clk) begin
    if (ise_rst) c_vld_q <= 1'b0;
    else if (acc && legal) c_vld_q <= 1'b1;
  end

  always_ff @(posedge ise_clk) begin
    if (acc && legal && !hit) begin
      c_tag_q <= {x_in, ise_imm[4:0]};
      c_r_q   <= r_in;
    end
  end
`else
  assign hit   = 1'b0;
  assign hit_r = '0;
`endif

  // Stage 1: both rotations registered at accept; held while BUSY
  logic [63:0] x_p1, rota_p1, rotb_p1, r_p1;
  logic        hi_p1;
  logic [31:0] res_p1, res_p2;

  always_ff @(posedge ise_clk) begin
    if (acc) begin
      x_p1    <= x_in;
      rota_p1 <= rota_in;
      rotb_p1 <= rotb_in;
      hi_p1   <= ise_imm[5];
    end
  end

  // Stage 2: XOR and half-select; the extra register only feeds PIPE=3
  assign r_p1   = x_p1 ^ rota_p1 ^ rotb_p1;
  assign res_p1 = hi_p1 ? r_p1[63:32] : r_p1[31:0];

  always_ff @(posedge ise_clk) begin
    res_p2 <= res_p1;
  end

  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rdy_q   <= 1'b1;
      oval_q  <= 1'b0;
      ill_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      oval_q <= 1'b0;
      ill_q  <= 1'b0;
      if (acc && !legal) begin
        state_q <= IDLE;
        cnt_q   <= 2'd0;
        rdy_q   <= 1'b1;
        ill_q   <= 1'b1;
        out_q   <= '0;
      end else if (acc && (hit || PIPE == 1)) begin
        state_q <= DONE;
        cnt_q   <= 2'd0;
        rdy_q   <= 1'b1;
        oval_q  <= 1'b1;
        out_q   <= hit ? hit_res : res_in;
      end else if (acc) begin
        state_q <= BUSY;
        cnt_q   <= 2'(PIPE - 1);
        rdy_q   <= 1'b0;
      end else begin
        case (state_q)
          BUSY: begin
            cnt_q <= cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
              state_q <= DONE;
              rdy_q   <= 1'b1;
              oval_q  <= 1'b1;
              out_q   <= (PIPE == 3) ? res_p2 : res_p1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ise_rdy  = en ? rdy_q : 1'b1;
  assign ise_oval = en & oval_q;
  assign ise_ill  = en & ill_q;
  assign ise_out  = out_q;

endmodule

// File: tb/tb_xalu_ise_mc.sv
// Bench for xalu_ise_mc: PIPE=1/2/3 units plus a disabled (ISE_V=01) unit against a row-function reference model.
module tb_xalu_ise_mc;
  localparam int NU = 4;
  localparam int PIPE_OF [NU] = '{1, 2, 3, 1};
  localparam bit ON_OF   [NU] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};
`ifdef XALU_ISE_PAIR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [NU];
  logic [5:0]  fn  [NU];
  logic [6:0]  imm [NU];
  logic [31:0] in1 [NU];
  logic [31:0] in2 [NU];
  logic        val [NU];
  logic        rdy [NU];
  logic        oval[NU];
  logic        ill [NU];
  logic [31:0] out [NU];

  xalu_ise_mc #(.ISE_V(2'b11), .PIPE(1)) u_p1 (
    .ise_clk(clk), .ise_rst(rst[0]), .ise_fn(fn[0]), .ise_imm(imm[0]), .ise_in1(in1[0]),
    .ise_in2(in2[0]), .ise_val(val[0]), .ise_rdy(rdy[0]), .ise_oval(oval[0]), .ise_ill(ill[0]),
    .ise_out(out[0]));
  xalu_ise_mc #(.ISE_V(2'b11), .PIPE(2)) u_p2 (
    .ise_clk(clk), .ise_rst(rst[1]), .ise_fn(fn[1]), .ise_imm(imm[1]), .ise_in1(in1[1]),
    .ise_in2(in2[1]), .ise_val(val[1]), .ise_rdy(rdy[1]), .ise_oval(oval[1]), .ise_ill(ill[1]),
    .ise_out(out[1]));
  xalu_ise_mc #(.ISE_V(2'b11), .PIPE(3)) u_p3 (
    .ise_clk(clk), .ise_rst(rst[2]), .ise_fn(fn[2]), .ise_imm(imm[2]), .ise_in1(in1[2]),
    .ise_in2(in2[2]), .ise_val(val[2]), .ise_rdy(rdy[2]), .ise_oval(oval[2]), .ise_ill(ill[2]),
    .ise_out(out[2]));
  xalu_ise_mc #(.ISE_V(2'b01), .PIPE(1)) u_off (
    .ise_clk(clk), .ise_rst(rst[3]), .ise_fn(fn[3]), .ise_imm(imm[3]), .ise_in1(in1[3]),
    .ise_in2(in2[3]), .ise_val(val[3]), .ise_rdy(rdy[3]), .ise_oval(oval[3]), .ise_ill(ill[3]),
    .ise_out(out[3]));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: last expected result word and the pair-cache contents
  logic [31:0] out_m [NU];
  bit          cvld  [NU];
  logic [68:0] ctag  [NU];

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [63:0] sigma(input logic [63:0] x, input int row);
    return x ^ rotr(x, RA[row]) ^ rotr(x, RB[row]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model(input int u, input logic [5:0] f, input logic [6:0] im, input logic [63:0] x,
                       output int lat_e, output logic ill_e, output logic [31:0] out_e);
    logic [63:0] r;
    int row;
    row   = int'(im[4:0]);
    lat_e = 0;
    ill_e = 1'b0;
    out_e = out_m[u];
    if (f[1:0] != 2'b01 || im[6] || !ON_OF[u]) return;
    if (row > 4) begin
      lat_e = 1;
      ill_e = 1'b1;
      out_e = '0;
    end else begin
      r     = sigma(x, row);
      out_e = im[5] ? r[63:32] : r[31:0];
      if (CACHE && cvld[u] && ctag[u] == {x, im[4:0]}) lat_e = 1;
      else lat_e = PIPE_OF[u];
      cvld[u] = 1'b1;
      ctag[u] = {x, im[4:0]};
    end
    out_m[u] = out_e;
  endtask

  task automatic op(input int u, input logic [5:0] f, input logic [6:0] im, input logic [63:0] x,
                    input string tag);
    int lat_e, lat;
    logic ill_e, o_s, i_s;
    logic [31:0] out_e, q_s;
    model(u, f, im, x, lat_e, ill_e, out_e);
    fn[u] = f; imm[u] = im; in1[u] = x[31:0]; in2[u] = x[63:32]; val[u] = 1'b1;
    @(negedge clk);
    val[u] = 1'b0; fn[u] = 6'($urandom); imm[u] = 7'($urandom); in1[u] = $urandom; in2[u] = $urandom;
    chk({tag, " rdy"}, 64'(rdy[u]), (lat_e >= 2) ? 64'd0 : 64'd1);
    lat = 0; o_s = 1'b0; i_s = 1'b0; q_s = '0;
    for (int k = 1; k <= 5; k++) begin
      if (oval[u] || ill[u]) begin
        lat = k; o_s = oval[u]; i_s = ill[u]; q_s = out[u];
        break;
      end
      if (k < 5) @(negedge clk);
    end
    chk({tag, " latency"}, 64'(lat), 64'(lat_e));
    if (lat_e == 0) begin
      chk({tag, " out held"}, 64'(out[u]), 64'(out_e));
    end else begin
      chk({tag, " oval"}, 64'(o_s), 64'(!ill_e));
      chk({tag, " ill"},  64'(i_s), 64'(ill_e));
      chk({tag, " out"},  64'(q_s), 64'(out_e));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    for (int u = 0; u < NU; u++) begin
      rst[u] = 1'b1; fn[u] = '0; imm[u] = '0; in1[u] = '0; in2[u] = '0; val[u] = 1'b0;
      out_m[u] = '0; cvld[u] = 1'b0; ctag[u] = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) rst[u] = 1'b0;
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("reset rdy u%0d", u),  64'(rdy[u]),  64'd1);
      chk($sformatf("reset oval u%0d", u), 64'(oval[u]), 64'd0);
      chk($sformatf("reset ill u%0d", u),  64'(ill[u]),  64'd0);
      chk($sformatf("reset out u%0d", u),  64'(out[u]),  64'd0);
    end

    // PIPE=1 basic sigma_lo / sigma_hi on x=1, row 0
    op(0, 6'h01, 7'h00, 64'h1, "p1 lo row0");
    chk("p1 lo row0 value", 64'(out[0]), 64'h00000001);
    op(0, 6'h01, 7'h20, 64'h1, "p1 hi row0");
    chk("p1 hi row0 value", 64'(out[0]), 64'h00002010);

    // PIPE=2 sigma_hi row 2, then an accept in the DONE cycle
    op(1, 6'h01, 7'h22, 64'h1, "p2 hi row2");
    chk("p2 hi row2 value", 64'(out[1]), 64'h84000000);
    op(1, 6'h01, 7'h02, 64'h2, "p2 b2b lo row2");

    // illegal row, unselected opcode class, imm[6] set, disabled unit
    op(0, 6'h01, 7'h05, 64'hDEAD_BEEF_0123_4567, "row5 ill");
    chk("row5 out zero", 64'(out[0]), 64'd0);
    op(0, 6'h00, 7'h00, 64'h1, "fn00 ignored");
    chk("fn00 rdy", 64'(rdy[0]), 64'd1);
    op(0, 6'h01, 7'h40, 64'h1, "imm6 ignored");
    op(3, 6'h01, 7'h00, 64'h1, "disabled unit");
    chk("disabled rdy", 64'(rdy[3]), 64'd1);

    // PIPE=3 reset one cycle after accept drops the op
    op(2, 6'h01, 7'h20, 64'h1, "p3 hi row0");
    fn[2] = 6'h01; imm[2] = 7'h01; in1[2] = 32'h5; in2[2] = 32'h0; val[2] = 1'b1;
    @(negedge clk);
    val[2] = 1'b0; rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0; out_m[2] = '0; cvld[2] = 1'b0;
    chk("p3 rst rdy",  64'(rdy[2]),  64'd1);
    chk("p3 rst oval", 64'(oval[2]), 64'd0);
    chk("p3 rst ill",  64'(ill[2]),  64'd0);
    chk("p3 rst out",  64'(out[2]),  64'd0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (oval[2] || ill[2]) pulses++;
      @(negedge clk);
    end
    chk("p3 no pulse after reset", 64'(pulses), 64'd0);

    // sigma_lo then sigma_hi on the same operands (single-cycle when the pair cache is built in)
    op(2, 6'h01, 7'h00, 64'h1, "p3 pair lo");
    op(2, 6'h01, 7'h20, 64'h1, "p3 pair hi");
    chk("p3 pair hi value", 64'(out[2]), 64'h00002010);

    // randomized ops against the reference model
    for (int u = 0; u < NU; u++) begin
      logic [63:0] lx;
      logic [4:0]  lrow;
      lx = 64'h1; lrow = 5'd0;
      for (int i = 0; i < 30; i++) begin
        logic [63:0] x;
        logic [6:0]  im;
        logic [5:0]  f;
        f = 6'($urandom);
        f[1:0] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b01;
        im = {1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 6))};
        if ($urandom_range(0, 2) == 0) begin
          x = lx; im[4:0] = lrow;
        end else begin
          x = {$urandom, $urandom};
        end
        op(u, f, im, x, $sformatf("rnd u%0d #%0d", u, i));
        if (im[4:0] <= 5'd4) begin
          lx = x; lrow = im[4:0];
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xalu_ise_mc.md
Name: xalu_ise_mc

Overview:
- Registered, parametrised successor to the combinational Ascon ISE ALU for the rv32 core.
- Executes Ascon sigma_lo / sigma_hi (64-bit linear-layer row function split across two 32-bit halves) through a configurable-depth pipeline.
- Uses a valid/ready request handshake and a one-cycle result pulse.
- Sits between the core's custom-instruction decode and writeback; the core stalls on ise_rdy and ise_oval.

Parameters:
- ISE_V, 2'b11: bit 1 enables the Ascon datapath; when 0 the block never asserts ise_oval or ise_ill, and ise_rdy is tied 1.
- PIPE, 1: cycles from accept to result, legal values 1..3; any other value is an elaboration error.

Ports:
- ise_clk  in  1  clock; all state on rising edge.
- ise_rst  in  1  synchronous active-high reset.
- ise_fn  in  6  opcode class; [1:0]==2'b01 (CUSTOM_1) selects this unit.
- ise_imm  in  7  funct; [6:5] 00=sigma_lo, 01=sigma_hi; [4:0]=row index.
- ise_in1  in  32  rs1, low word of x.
- ise_in2  in  32  rs2, high word of x.
- ise_val  in  1  request valid.
- ise_rdy  out  1  unit can accept this cycle.
- ise_oval  out  1  one-cycle result-valid pulse.
- ise_ill  out  1  one-cycle pulse: row index > 4.
- ise_out  out  32  result; held until the next ise_oval or ise_ill.

Behaviour:
- Clock and reset: one clock, ise_clk; reset ise_rst is synchronous and active-high.
- Op select: sel = ise_fn[1:0]==2'b01 && ise_imm[6]==0. Requests with sel=0 are ignored: no accept, no pulse, no state change.
- Accept: ise_val && ise_rdy && sel. At accept, the block registers {in2,in1}, row=ise_imm[4:0], and hi=ise_imm[5].
- Row function: x={in2,in1}; r = x ^ ror64(x,a) ^ ror64(x,b), where the row sets (a,b) as follows:
  - row 0: (19,28)
  - row 1: (61,39)
  - row 2: (1,6)
  - row 3: (10,17)
  - row 4: (7,41)
- Output selection: sigma_lo outputs r[31:0]; sigma_hi outputs r[63:32].
- Pipeline split:
  - PIPE=1: whole function computed in the accept-to-result stage.
  - PIPE=2: stage 1 registers both rotations; stage 2 XORs and selects.
  - PIPE=3: adds an output register after stage 2.
- Timing: accept at cycle t gives ise_oval=1 at t+PIPE, with ise_out valid in that same cycle.
- FSM states:
  - IDLE: ise_rdy=1; accept moves to BUSY with cnt=PIPE-1; if PIPE==1, moves to DONE.
  - BUSY: ise_rdy=0; cnt decrements; moves to DONE when cnt==0.
  - DONE: ise_oval=1, ise_rdy=1. An accept in DONE re-enters BUSY (or DONE if PIPE==1), giving back-to-back throughput of one op per PIPE cycles. With no accept, returns to IDLE.
- Illegal row: if row > 4 at accept, the op skips the pipeline. ise_ill pulses at t+1, ise_out=0, ise_oval stays 0, and the FSM returns to IDLE (or DONE→IDLE).
- Input changes: ise_val or operand changes while BUSY are ignored; operands are sampled only at accept.
- Reset: ise_rdy=1, ise_oval=0, ise_ill=0, ise_out=0, state=IDLE, cnt=0, cache invalid. Reset mid-operation drops the in-flight op with no pulse afterwards.

Optional Feature:
- Macro: XALU_ISE_PAIR_CACHE_EN.
- Enabled:
  - The block stores the last legal accepted {in2,in1,row} tag and its full 64-bit r, with a valid bit.
  - An accepted op whose tag matches a valid entry completes at t+1 regardless of PIPE. This makes a sigma_hi that follows a sigma_lo on the same operands single-cycle.
  - The cache is updated on every legal computed op and cleared by reset.
- Disabled: no tag storage; every op takes PIPE cycles.

Test Plan:
- PIPE=1: x=64'h1, row 0, sigma_lo → ise_oval at t+1, out=32'h00000001; sigma_hi → 32'h00002010.
- PIPE=2: x=64'h1, row 2, sigma_hi → ise_rdy=0 at t+1, ise_oval at t+2, out=32'h84000000; back-to-back accept in the DONE cycle gives the next oval at t+4.
- Row 5 (ise_imm=7'h05) → ise_ill pulse at t+1, ise_out=0, no ise_oval.
- ise_fn[1:0]=2'b00 with ise_val=1 → no accept, no pulses, state stays IDLE.
- PIPE=3, ise_rst asserted at t+1 after an accept → ise_oval never asserts; all outputs at reset values the next cycle.
- With XALU_ISE_PAIR_CACHE_EN and PIPE=3: sigma_lo then sigma_hi, x=64'h1, row 0 → second op oval at +1 with out=32'h00002010.
